// File: rtl/mem_lsu_if.sv
// Data-bus interface between the memory-stage LSU (master) and the data memory (slave).
// Request/acknowledge protocol: dreq held until a single-cycle dack; drdata valid while dack=1.
interface mem_lsu_if;
  logic        dreq;
  logic        dwe;
  logic [31:0] daddr;
  logic [3:0]  dsel;
  logic [31:0] dwdata;
  logic        dack;
  logic [31:0] drdata;

  modport master (output dreq, dwe, daddr, dsel, dwdata, input dack, drdata);
  modport slave  (input dreq, dwe, daddr, dsel, dwdata, output dack, drdata);
endinterface

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit; define LSU_ALIGN_CHECK_EN to trap misaligned accesses.
// Latency: non-memory ops 0 cycles; accesses stall >=2 cycles until dack; DONE held while stall[4]=1.
module mem_lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_data,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [3:0]  mem_lsop,
  input  logic [31:0] mem_memaddr,
  input  logic [31:0] mem_reg2,
  input  logic [5:0]  stall,
  output logic        stallreq_mem,
  output logic [31:0] wb_wdata,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  mem_lsu_if.master   dbus,
  output logic        misalign
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state;
  logic [31:0] ld_q;
  logic        is_load, is_store, misaligned, access;
  logic [3:0]  sel_n;
  logic [31:0] wdat_n;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  // Only stall[4] (MEM/WB hold) concerns this stage.
  logic unused_stall;
  assign unused_stall = ^{stall[5], stall[3:0]};

  assign is_load  = (mem_lsop >= OP_LB) && (mem_lsop <= OP_LW);
  assign is_store = (mem_lsop >= OP_SB) && (mem_lsop <= OP_SW);

`ifdef LSU_ALIGN_CHECK_EN
  assign misaligned = (((mem_lsop == OP_LH) || (mem_lsop == OP_LHU) || (mem_lsop == OP_SH))
                       && mem_memaddr[0])
                   || (((mem_lsop == OP_LW) || (mem_lsop == OP_SW)) && (mem_memaddr[1:0] != 2'b00));
  assign misalign   = (state == IDLE) && (is_load || is_store) && misaligned;
`else
  assign misaligned = 1'b0;
  assign misalign   = 1'b0;
`endif

  assign access       = (is_load || is_store) && !misaligned;
  assign stallreq_mem = ((state == IDLE) && access) || (state == REQ);

  always_comb begin
    sel_n  = 4'b1111;
    wdat_n = mem_reg2;
    case (mem_lsop)
      OP_LB, OP_LBU, OP_SB: begin
        sel_n  = 4'b0001 << mem_memaddr[1:0];
        wdat_n = {4{mem_reg2[7:0]}};
      end
      OP_LH, OP_LHU, OP_SH: begin
        sel_n  = mem_memaddr[1] ? 4'b1100 : 4'b0011;
        wdat_n = {2{mem_reg2[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane extraction relies on mem_memaddr staying frozen through REQ/DONE.
  always_comb begin
    case (mem_memaddr[1:0])
      2'd0:    ld_byte = ld_q[7:0];
      2'd1:    ld_byte = ld_q[15:8];
      2'd2:    ld_byte = ld_q[23:16];
      default: ld_byte = ld_q[31:24];
    endcase
    ld_half = mem_memaddr[1] ? ld_q[31:16] : ld_q[15:0];
    case (mem_lsop)
      OP_LB:   ld_ext = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_ext = {24'd0, ld_byte};
      OP_LH:   ld_ext = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_ext = {16'd0, ld_half};
      default: ld_ext = ld_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      dbus.dreq   <= 1'b0;
      dbus.dwe    <= 1'b0;
      dbus.daddr  <= 32'd0;
      dbus.dsel   <= 4'd0;
      dbus.dwdata <= 32'd0;
      ld_q        <= 32'd0;
    end else begin
      case (state)
        IDLE: if (access) begin
          state       <= REQ;
          dbus.dreq   <= 1'b1;
          dbus.dwe    <= is_store;
          dbus.daddr  <= {mem_memaddr[31:2], 2'b00};
          dbus.dsel   <= sel_n;
          dbus.dwdata <= wdat_n;
        end
        REQ: if (dbus.dack) begin
          state     <= DONE;
          dbus.dreq <= 1'b0;
          ld_q      <= dbus.drdata;
        end
        DONE: if (!stall[4]) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Memory ops only write back from DONE; stores never write back.
  always_comb begin
    wb_wd    = mem_wd;
    wb_wdata = mem_data;
    wb_wreg  = 1'b0;
    case (state)
      IDLE: wb_wreg = mem_wreg && !(is_load || is_store);
      DONE: if (is_load) begin
        wb_wdata = ld_ext;
        wb_wreg  = mem_wreg;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Memory-stage load/store unit for the 5-stage pipeline. It consumes the registered EX/MEM outputs (write-back data, destination, load/store opcode, address, store data), runs a request/acknowledge transaction on the data bus, and sign- or zero-extends load data. It drives the MEM/WB inputs and raises a stall request to the pipeline controller for every access until the bus acknowledges. Non-memory instructions pass straight through with zero added latency.

## Interface
Parameters: none. Widths fixed: data/address 32, register index 5, opcode 4.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- mem_data  in  32  ALU result / write-back data from EX/MEM
- mem_wd  in  5  destination register
- mem_wreg  in  1  register write enable
- mem_lsop  in  4  load/store opcode
- mem_memaddr  in  32  effective address
- mem_reg2  in  32  store data
- stall  in  6  controller stall vector; stall[4] holds MEM/WB
- stallreq_mem  out  1  stall request to controller
- wb_wdata  out  32  data to MEM/WB
- wb_wd  out  5  destination to MEM/WB
- wb_wreg  out  1  write enable to MEM/WB
- dreq  out  1  bus request
- dwe  out  1  bus write enable
- daddr  out  32  bus address, bits [1:0] always 0
- dsel  out  4  byte-lane enables, lane 0 = bits [7:0], little-endian
- dwdata  out  32  bus write data
- dack  in  1  bus acknowledge, single-cycle pulse
- drdata  in  32  bus read data, valid while dack=1
- misalign  out  1  misaligned-access flag

## Operation
- mem_lsop: 0 NOP, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9–15 are treated as NOP.
- The FSM has three states: IDLE, REQ, DONE.
- IDLE, memory opcode present: stallreq_mem=1 combinationally. At the next edge the FSM enters REQ and registers daddr={addr[31:2],2'b00}, dsel, dwdata and dwe.
- IDLE, no memory opcode: stallreq_mem=0; wb_* = mem_data/mem_wd/mem_wreg.
- REQ: dreq=1 and stallreq_mem=1, held stable until dack. When dack=1, drdata is captured into the load register and the FSM enters DONE.
- DONE: dreq=0, stallreq_mem=0. wb_wdata = extended load value for loads and mem_data for stores. wb_wreg = mem_wreg for loads and 0 for stores. The FSM returns to IDLE when stall[4]=0 and holds DONE while stall[4]=1.
- Store lanes:
  - SB: dsel=4'b0001<<addr[1:0], byte replicated 4×.
  - SH: dsel=addr[1]?4'b1100:4'b0011, halfword replicated 2×.
  - SW: dsel=4'b1111.
- Load extraction: select the byte at addr[1:0] or the halfword at addr[1]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes all 32 bits.
- While in REQ or DONE, the mem_* inputs stay frozen because the controller stall holds EX/MEM. The unit relies on this and does not re-latch the inputs.

## Timing
- Reset (async, rst_n=0): state goes to IDLE immediately. dreq, dwe, daddr, dsel, dwdata, the load register and misalign are all 0.
- A reset asserted during REQ abandons the transaction; the bus slave must tolerate the dropped dreq.
- Minimum memory-op latency is 3 cycles (IDLE, REQ with dack, DONE), which is 2 stall cycles. Each extra wait cycle on dack adds 1 stall.
- Non-memory ops: 0 cycles added; the unit is combinational from the mem_* inputs to wb_*.
- dack while not in REQ: ignored.
- dack and stall[4]=1 in the same cycle: the data is still captured and the FSM enters DONE, then holds there.

## Configuration
- LSU_ALIGN_CHECK_EN defined:
  - A misaligned access is LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
  - On a misaligned access in IDLE: no bus request, stallreq_mem=0, wb_wreg=0, misalign=1 for that cycle.
- LSU_ALIGN_CHECK_EN undefined:
  - misalign is tied to 0.
  - The offending low address bits are ignored: halfword accesses use addr[1], word accesses use the aligned address.

## Test plan
- LW addr=0x100, dack on the second REQ cycle, drdata=0xDEADBEEF:
  - dreq high for 2 cycles, daddr=0x100, dsel=4'hF;
  - stallreq_mem high for 3 cycles;
  - in DONE, wb_wdata=0xDEADBEEF and wb_wreg=1.
- LB addr=0x103, drdata=0x80FF_FFFF: wb_wdata=0xFFFFFF80. LBU at the same address and data: wb_wdata=0x00000080.
- SH addr=0x202, reg2=0x1234ABCD: dwe=1, dsel=4'b1100, dwdata=0xABCDABCD, daddr=0x200; in DONE, wb_wreg=0.
- ADD passthrough, mem_lsop=0, mem_data=5, mem_wd=3: stallreq_mem=0, wb_wdata=5, wb_wd=3, and dreq never asserted.
- rst_n pulled low during REQ: dreq drops in the same cycle, FSM returns to IDLE, no write-back occurs.
- LW addr=0x101:
  - with LSU_ALIGN_CHECK_EN: misalign=1, no dreq, wb_wreg=0;
  - without: daddr=0x100, normal access.
